ripple_count_sampler: RTL and testbench



---
 rtl/ripple_count_sampler.sv | 140 ++++++++++++++
 tb/tb_ripple_count_sampler.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ripple_count_sampler.sv
// Samples an asynchronous ripple-counter value into the clk domain, accepts it once stable
// (or forces it after a timeout) and presents count, delta and wrap over valid/ready.
module ripple_count_sampler #(
  parameter int WIDTH   = 8,
  parameter int STABLE  = 2,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] q_in,
  input  logic             sample_req,
  output logic             busy,
  output logic             valid,
  input  logic             ready,
  output logic [WIDTH-1:0] cnt_out,
  output logic [WIDTH-1:0] delta_out,
  output logic             wrap_out,
  output logic             err_out
);

  localparam int SW = $clog2(STABLE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STAB_MAX = SW'(STABLE);
  localparam logic [TW-1:0] TOUT_MAX = TW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] ref_val;
  logic [SW-1:0]    stab;
  logic [TW-1:0]    tcnt;
  logic [WIDTH-1:0] last_cnt;

  logic [WIDTH-1:0] ref_nx;
  logic [SW-1:0]    stab_nx;
  logic [TW-1:0]    tcnt_nx;
  logic             stable_hit;
  logic             timeout_hit;
  logic [WIDTH-1:0] captured;

  // Every q_in bit may be mid-ripple when sampled; the second stage filters metastability.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= q_in;
      sync2 <= sync1;
    end
  end

  // stab == 0 marks the first SETTLE cycle, since IDLE always clears it.
  always_comb begin
    // NOTE: defaults first so no path through this block leaves a signal unassigned (no latches).
    ref_nx  = ref_val;
    stab_nx = stab;
    tcnt_nx = tcnt + 1'b1;
    if (stab == '0) begin
      ref_nx  = sync2;
      stab_nx = SW'(1);
      tcnt_nx = TW'(1);
    end else if (sync2 == ref_val) begin
      stab_nx = stab + 1'b1;
    end else begin
      ref_nx  = sync2;
      stab_nx = SW'(1);
    end
    stable_hit  = (stab_nx == STAB_MAX);
    timeout_hit = (tcnt_nx == TOUT_MAX);
    captured    = stable_hit ? ref_nx : sync2;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ref_val   <= '0;
      stab      <= '0;
      tcnt      <= '0;
      last_cnt  <= '0;
      cnt_out   <= '0;
      delta_out <= '0;
      wrap_out  <= 1'b0;
      err_out   <= 1'b0;
      busy      <= 1'b0;
      valid     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ref_val <= '0;
          stab    <= '0;
          if (sample_req) begin
            state <= SETTLE;
            busy  <= 1'b1;
          end
        end
        SETTLE: begin
          ref_val <= ref_nx;
          stab    <= stab_nx;
          tcnt    <= tcnt_nx;
          // Stability is checked first so a simultaneous timeout still reports a clean capture.
          if (stable_hit || timeout_hit) begin
            state     <= HOLD;
            valid     <= 1'b1;
            cnt_out   <= captured;
            delta_out <= captured - last_cnt;
            wrap_out  <= (captured < last_cnt);
            err_out   <= !stable_hit;
          end
        end
        HOLD: begin
          if (ready) begin
            last_cnt <= cnt_out;
            state    <= IDLE;
            valid    <= 1'b0;
            busy     <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          valid <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  a_valid_busy : assert property (@(posedge clk) valid |-> busy);

  a_hold_stable : assert property (@(posedge clk) disable iff (reset)
    (valid && !ready) |=> (valid && $stable(cnt_out) && $stable(delta_out)
                           && $stable(wrap_out) && $stable(err_out)));

endmodule

// File: tb/tb_ripple_count_sampler.sv
// Randomised and directed bench for ripple_count_sampler against a transaction-level model
// built from the recorded per-edge q_in/reset history.
module tb_ripple_count_sampler;

  localparam int WIDTH    = 8;
  localparam int STABLE   = 2;
  localparam int TIMEOUT  = 16;
  localparam int PLAN_LEN = TIMEOUT + 4;
  localparam int HIST     = 8192;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] q_in = '0;
  logic             sample_req = 1'b0;
  logic             ready = 1'b0;
  logic             busy;
  logic             valid;
  logic [WIDTH-1:0] cnt_out;
  logic [WIDTH-1:0] delta_out;
  logic             wrap_out;
  logic             err_out;

  ripple_count_sampler #(.WIDTH(WIDTH), .STABLE(STABLE), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .q_in       (q_in),
    .sample_req (sample_req),
    .busy       (busy),
    .valid      (valid),
    .ready      (ready),
    .cnt_out    (cnt_out),
    .delta_out  (delta_out),
    .wrap_out   (wrap_out),
    .err_out    (err_out)
  );

  always #5 clk = ~clk;

  // Per-edge record of what the DUT sampled: edge n stores q_in and reset seen at that edge.
  int         edge_n = 0;
  logic [7:0] qh [HIST];
  logic       rh [HIST];

  always @(posedge clk) begin
    if (edge_n < HIST) begin
      qh[edge_n] <= q_in;
      rh[edge_n] <= reset;
    end
    edge_n <= edge_n + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Model state
  logic [7:0] plan [PLAN_LEN];
  int         cur_k = 0;
  logic [7:0] last_cnt_m = '0;
  int         exp_e;
  int         e_obs;
  logic [7:0] exp_v;
  logic [7:0] exp_d;
  logic       exp_w;
  logic       exp_er;

  // Value the synchroniser output holds just before edge m, for a request sampled at edge k.
  function automatic logic [7:0] s2_at(input int m, input int k);
    int         j;
    logic       r1;
    logic       r2;
    logic [7:0] q;
    j  = m - 2;
    r1 = (m - 1 >= k) ? 1'b0 : rh[m-1];
    r2 = (j >= k) ? 1'b0 : rh[j];
    q  = (j >= k) ? plan[j-k] : qh[j];
    return (r1 || r2) ? 8'h00 : q;
  endfunction

  // Capture at the first edge whose last STABLE samples in the window all agree, else forced.
  task automatic predict(input int k, output int e, output logic [7:0] v, output logic er);
    bit same;
    bit found;
    found = 0;
    e  = k + TIMEOUT;
    v  = s2_at(k + TIMEOUT, k);
    er = 1'b1;
    for (int c = k + STABLE; c <= k + TIMEOUT; c++) begin
      if (!found) begin
        same = 1;
        for (int j = 1; j < STABLE; j++)
          if (s2_at(c - j, k) != s2_at(c, k)) same = 0;
        if (same) begin
          found = 1;
          e  = c;
          v  = s2_at(c, k);
          er = 1'b0;
        end
      end
    end
  endtask

  task automatic tick();
    int idx;
    @(posedge clk);
    #1;
    sample_req = 1'b0;
    idx = edge_n - cur_k;
    q_in = (idx < PLAN_LEN) ? plan[idx] : plan[PLAN_LEN-1];
  endtask

  task automatic hold_q(input logic [7:0] val, input int n);
    for (int i = 0; i < PLAN_LEN; i++) plan[i] = val;
    cur_k = edge_n;
    q_in  = val;
    repeat (n) tick();
  endtask

  // mode 0 static, 1 changes every cycle, 2 random noisy, 3 plan preloaded by caller
  task automatic start_req(input int mode, input logic [7:0] base);
    if (mode != 3) begin
      plan[0] = base;
      for (int i = 1; i < PLAN_LEN; i++) begin
        case (mode)
          0:       plan[i] = base;
          1:       plan[i] = plan[i-1] + 8'd1;
          default: plan[i] = ($urandom_range(0, 2) == 0) ? plan[i-1] + 8'($urandom_range(1, 3))
                                                          : plan[i-1];
        endcase
      end
    end
    cur_k      = edge_n;
    q_in       = plan[0];
    sample_req = 1'b1;
    predict(cur_k, exp_e, exp_v, exp_er);
    exp_d = exp_v - last_cnt_m;
    exp_w = (exp_v < last_cnt_m);
  endtask

  task automatic wait_valid(output bit got);
    got = 0;
    for (int i = 0; i < TIMEOUT + 4; i++) begin
      if (!got) begin
        tick();
        if (edge_n - 1 == cur_k) check("busy_settle", 32'({busy, valid}), 32'b10);
        if (valid) begin
          got   = 1;
          e_obs = edge_n - 1;
        end
      end
    end
    if (!got) check("valid_timeout", 32'(0), 32'(1));
  endtask

  task automatic check_capture(input string name);
    check({name, "_lat"},   32'(e_obs - cur_k), 32'(exp_e - cur_k));
    check({name, "_cnt"},   32'(cnt_out),   32'(exp_v));
    check({name, "_delta"}, 32'(delta_out), 32'(exp_d));
    check({name, "_wrap"},  32'(wrap_out),  32'(exp_w));
    check({name, "_err"},   32'(err_out),   32'(exp_er));
  endtask

  task automatic finish_txn(input int bp, input bit stray);
    for (int i = 0; i < bp; i++) begin
      if (stray && i == bp / 2) sample_req = 1'b1;
      tick();
      check("hold", 32'({valid, cnt_out, delta_out, wrap_out, err_out}),
            32'({1'b1, exp_v, exp_d, exp_w, exp_er}));
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    last_cnt_m = exp_v;
    check("drop", 32'({valid, busy}), 32'(0));
    if (stray) begin
      repeat (2) begin
        tick();
        check("no_second", 32'({valid, busy}), 32'(0));
      end
    end
  endtask

  task automatic run_txn(input string name, input int mode, input logic [7:0] base,
                         input int bp, input bit stray);
    bit got;
    check({name, "_idle"}, 32'(busy), 32'(0));
    start_req(mode, base);
    wait_valid(got);
    if (got) begin
      check_capture(name);
      finish_txn(bp, stray);
    end
  endtask

  task automatic check_zero(input string name);
    check({name, "_busy"},  32'(busy),      32'(0));
    check({name, "_valid"}, 32'(valid),     32'(0));
    check({name, "_cnt"},   32'(cnt_out),   32'(0));
    check({name, "_delta"}, 32'(delta_out), 32'(0));
    check({name, "_wrap"},  32'(wrap_out),  32'(0));
    check({name, "_err"},   32'(err_out),   32'(0));
  endtask

  initial begin
    bit got;
    bit seen;
    for (int i = 0; i < PLAN_LEN; i++) plan[i] = '0;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    check_zero("por");

    hold_q(8'h05, 4);
    run_txn("static", 0, 8'h05, 0, 0);
    check("static_lat_c", 32'(e_obs - cur_k), 32'(STABLE));
    check("static_cnt_c", 32'(cnt_out), 32'h05);

    hold_q(8'h02, 3);
    run_txn("wrap", 0, 8'h02, 0, 0);
    check("wrap_delta_c", 32'(exp_d), 32'hFD);
    check("wrap_flag_c",  32'(exp_w), 32'(1));

    hold_q(8'h0A, 3);
    for (int i = 0; i < PLAN_LEN; i++) plan[i] = 8'h10;
    plan[0] = 8'h0F;
    plan[2] = 8'h0F;
    run_txn("glitch", 3, 8'h00, 0, 0);
    check("glitch_cnt_c", 32'(exp_v),  32'h10);
    check("glitch_err_c", 32'(exp_er), 32'(0));

    hold_q(8'h20, 3);
    run_txn("forced", 1, 8'h21, 0, 0);
    check("forced_err_c", 32'(exp_er), 32'(1));
    check("forced_by_17", 32'((e_obs - cur_k) <= TIMEOUT), 32'(1));

    hold_q(8'h40, 3);
    run_txn("bp", 0, 8'h40, 5, 1);
    hold_q(8'h44, 3);
    run_txn("after_bp", 0, 8'h44, 0, 0);
    check("after_bp_delta_c", 32'(exp_d), 32'h04);

    // Reset while a result is pending
    hold_q(8'h55, 3);
    start_req(0, 8'h55);
    wait_valid(got);
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    last_cnt_m = '0;
    check_zero("rst_hold");
    tick();
    check("rst_hold_idle", 32'(busy), 32'(0));

    // Reset one cycle into SETTLE
    hold_q(8'h07, 3);
    start_req(0, 8'h07);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_settle", 32'({busy, valid}), 32'(0));
    seen = 0;
    repeat (5) begin
      tick();
      seen |= valid;
    end
    check("rst_settle_novalid", 32'(seen), 32'(0));
    last_cnt_m = '0;
    hold_q(8'h07, 3);
    run_txn("post_rst", 0, 8'h07, 0, 0);
    check("post_rst_delta_c", 32'(exp_d), 32'h07);

    for (int t = 0; t < 40; t++) begin
      int bp;
      bp = $urandom_range(0, 4);
      hold_q(8'($urandom_range(0, 255)), $urandom_range(0, 3));
      run_txn("rand", $urandom_range(0, 2), 8'($urandom_range(0, 255)), bp,
              (bp > 0) && ($urandom_range(0, 1) == 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
